// File: rtl/execute_mem_storedrain_pkg.sv
`default_nettype none
// ============================================================================
// Module   : execute_mem_storedrain_pkg
// Desc     : Shared types and constants for the store-buffer drain engine.
// Revision : 1.0 - initial release
// ============================================================================
package execute_mem_storedrain_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CWR   = 2'd1,
        ST_UADDR = 2'd2,
        ST_URESP = 2'd3
    } state_t;

    localparam logic [1:0] c_LSW_BYTE = 2'd0;
    localparam logic [1:0] c_LSW_HALF = 2'd1;
    localparam logic [1:0] c_LSW_WORD = 2'd2;

    localparam logic [1:0] c_BRESP_OKAY   = 2'b00;
    localparam logic [1:0] c_BRESP_EXOKAY = 2'b01;
    localparam logic [1:0] c_BRESP_SLVERR = 2'b10;
    localparam logic [1:0] c_BRESP_DECERR = 2'b11;

    localparam int c_SB_DEPTH = 6;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/execute_mem_storedrain_axiw.sv
`default_nettype none
// ============================================================================
// Module   : execute_mem_storedrain_axiw
// Desc     : Single-beat AXI4-Lite write: independent AW/W handshakes, then B.
// Revision : 1.0 - initial release
// ============================================================================
module execute_mem_storedrain_axiw
    import execute_mem_storedrain_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_size,
    input  logic [31:0] req_data,
    input  logic [3:0]  req_strb,
    output logic        awvalid,
    output logic [31:0] awaddr,
    output logic [2:0]  awsize,
    input  logic        awready,
    output logic        wvalid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    input  logic        wready,
    input  logic        bvalid,
    input  logic [1:0]  bresp,
    output logic        bready,
    output logic        addr_done,
    output logic        done,
    output logic        done_err
);

    logic        r_awvalid, r_wvalid, r_bready, r_addr_phase;
    logic [31:0] r_awaddr, r_wdata;
    logic [2:0]  r_awsize;
    logic [3:0]  r_wstrb;
    logic        w_aw_left, w_w_left;

    // A channel still owes a handshake if it is valid and not accepted this cycle.
    assign w_aw_left = r_awvalid && !awready;
    assign w_w_left  = r_wvalid && !wready;
    assign addr_done = r_addr_phase && !w_aw_left && !w_w_left;
    assign done      = r_bready && bvalid;
    assign done_err  = done && (bresp != c_BRESP_OKAY);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_awvalid    <= 1'b0;
            r_wvalid     <= 1'b0;
            r_bready     <= 1'b0;
            r_addr_phase <= 1'b0;
            r_awaddr     <= '0;
            r_awsize     <= '0;
            r_wdata      <= '0;
            r_wstrb      <= '0;
        end else if (start) begin
            r_awvalid    <= 1'b1;
            r_wvalid     <= 1'b1;
            r_addr_phase <= 1'b1;
            r_awaddr     <= req_addr;
            r_awsize     <= req_size;
            r_wdata      <= req_data;
            r_wstrb      <= req_strb;
        end else begin
            r_awvalid <= w_aw_left;
            r_wvalid  <= w_w_left;
            if (addr_done) begin
                r_addr_phase <= 1'b0;
                r_bready     <= 1'b1;
            end
            if (done) begin
                r_bready <= 1'b0;
            end
        end
    end

    assign awvalid = r_awvalid;
    assign awaddr  = r_awaddr;
    assign awsize  = r_awsize;
    assign wvalid  = r_wvalid;
    assign wdata   = r_wdata;
    assign wstrb   = r_wstrb;
    assign bready  = r_bready;

endmodule
`default_nettype wire

// File: rtl/execute_mem_storedrain.sv
`default_nettype none
// ============================================================================
// Module   : execute_mem_storedrain
// Desc     : Drains committed store-buffer head entries to D-cache or AXI4-Lite.
// Options  : STOREDRAIN_BUS_ERROR_EN adds a sticky bus_error output.
// Revision : 1.0 - initial release
// ============================================================================
module execute_mem_storedrain
    import execute_mem_storedrain_pkg::*;
#(
    parameter int PEND_W = 3
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        commit_store,
    input  logic        sb_valid,
    input  logic [31:0] sb_addr,
    input  logic [3:0]  sb_strb,
    input  logic [1:0]  sb_lswidth,
    input  logic [31:0] sb_data,
    input  logic        sb_uncached,
    output logic        sb_pop,
    output logic        dc_wreq,
    output logic [31:0] dc_waddr,
    output logic [3:0]  dc_wstrb,
    output logic [31:0] dc_wdata,
    input  logic        dc_wready,
    output logic        awvalid,
    output logic [31:0] awaddr,
    output logic [2:0]  awsize,
    input  logic        awready,
    output logic        wvalid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    input  logic        wready,
    input  logic        bvalid,
    input  logic [1:0]  bresp,
    output logic        bready,
`ifdef STOREDRAIN_BUS_ERROR_EN
    output logic        bus_error,
`endif
    output logic        busy
);

    state_t            r_state, w_state_next;
    logic [PEND_W-1:0] r_pending;
    logic              r_sb_pop, r_dc_wreq, r_flushed;
    logic [31:0]       r_dc_waddr, r_dc_wdata;
    logic [3:0]        r_dc_wstrb;
    logic              w_start, w_axi_start, w_dc_hs;
    logic              w_addr_done, w_axi_done, w_axi_err;
    logic [31:0]       w_awaddr_req;

    // A commit in the same cycle counts, so a cached write issues the cycle after commit.
    // The cycle sb_pop is high the head is stale, so no new request starts then.
    assign w_start     = (r_state == ST_IDLE) && !flush && !r_sb_pop && sb_valid &&
                         ((r_pending != '0) || commit_store);
    assign w_axi_start = w_start && sb_uncached;
    assign w_dc_hs     = r_dc_wreq && dc_wready;
    assign w_awaddr_req = (sb_lswidth == c_LSW_WORD) ? word_align(sb_addr) : sb_addr;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_pending <= '0;
        end else if (commit_store && !r_sb_pop) begin
            if (r_pending != PEND_W'(c_SB_DEPTH)) r_pending <= r_pending + PEND_W'(1);
        end else if (!commit_store && r_sb_pop) begin
            if (r_pending != '0) r_pending <= r_pending - PEND_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_start) w_state_next = sb_uncached ? ST_UADDR : ST_CWR;
            ST_CWR:   if (w_dc_hs || flush) w_state_next = ST_IDLE;
            ST_UADDR: if (w_addr_done) w_state_next = ST_URESP;
            ST_URESP: if (w_axi_done) w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sb_pop   <= 1'b0;
            r_dc_wreq  <= 1'b0;
            r_flushed  <= 1'b0;
            r_dc_waddr <= '0;
            r_dc_wstrb <= '0;
            r_dc_wdata <= '0;
        end else begin
            r_sb_pop <= 1'b0;
            if (w_start) begin
                r_flushed <= 1'b0;
                if (!sb_uncached) begin
                    r_dc_wreq  <= 1'b1;
                    r_dc_waddr <= word_align(sb_addr);
                    r_dc_wstrb <= sb_strb;
                    r_dc_wdata <= sb_data;
                end
            end
            if (r_state == ST_CWR) begin
                if (w_dc_hs) begin
                    r_dc_wreq <= 1'b0;
                    r_sb_pop  <= !flush;
                end else if (flush) begin
                    r_dc_wreq <= 1'b0;
                end
            end
            // A flushed AXI write still runs to completion but must not pop the new buffer.
            if ((r_state == ST_UADDR || r_state == ST_URESP) && flush) begin
                r_flushed <= 1'b1;
            end
            if (w_axi_done) begin
                r_sb_pop <= !r_flushed && !flush;
            end
        end
    end

    execute_mem_storedrain_axiw u_axiw (
        .clk       (clk),
        .reset     (reset),
        .start     (w_axi_start),
        .req_addr  (w_awaddr_req),
        .req_size  ({1'b0, sb_lswidth}),
        .req_data  (sb_data),
        .req_strb  (sb_strb),
        .awvalid   (awvalid),
        .awaddr    (awaddr),
        .awsize    (awsize),
        .awready   (awready),
        .wvalid    (wvalid),
        .wdata     (wdata),
        .wstrb     (wstrb),
        .wready    (wready),
        .bvalid    (bvalid),
        .bresp     (bresp),
        .bready    (bready),
        .addr_done (w_addr_done),
        .done      (w_axi_done),
        .done_err  (w_axi_err)
    );

`ifdef STOREDRAIN_BUS_ERROR_EN
    logic r_bus_error;
    always_ff @(posedge clk) begin
        if (reset)          r_bus_error <= 1'b0;
        else if (w_axi_err) r_bus_error <= 1'b1;
    end
    assign bus_error = r_bus_error;
`else
    logic w_unused_axi_err;
    assign w_unused_axi_err = w_axi_err;
`endif

    assign sb_pop   = r_sb_pop;
    assign dc_wreq  = r_dc_wreq;
    assign dc_waddr = r_dc_waddr;
    assign dc_wstrb = r_dc_wstrb;
    assign dc_wdata = r_dc_wdata;
    assign busy     = (r_state != ST_IDLE) || (r_pending != '0);

endmodule
`default_nettype wire

// File: tb/tb_execute_mem_storedrain.sv
`default_nettype none
// ============================================================================
// Module   : tb_execute_mem_storedrain
// Desc     : Directed self-checking bench for the store-buffer drain engine.
// Revision : 1.0 - initial release
// ============================================================================
module tb_execute_mem_storedrain;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [1:0]  lsw;
        logic [31:0] data;
        logic        unc;
    } st_t;

    logic        clk = 1'b0;
    logic        reset, flush, commit_store, sb_valid, sb_uncached;
    logic [31:0] sb_addr, sb_data;
    logic [3:0]  sb_strb;
    logic [1:0]  sb_lswidth;
    logic        sb_pop, dc_wreq, dc_wready;
    logic [31:0] dc_waddr, dc_wdata;
    logic [3:0]  dc_wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready, busy;
    logic [31:0] awaddr, wdata;
    logic [2:0]  awsize;
    logic [3:0]  wstrb;
    logic [1:0]  bresp;
`ifdef STOREDRAIN_BUS_ERROR_EN
    logic        bus_error;
`endif

    int          n_tests = 0;
    int          n_fail  = 0;
    st_t         q[$];
    logic [31:0] wlog[$];
    int          m_pending = 0;
    int          pop_cnt = 0;
    logic        prev_pop = 1'b0;
    logic        armed = 1'b0;
    int          dc_stall = 0;
    int          dc_wait = 0;

    execute_mem_storedrain #(.PEND_W(3)) dut (
        .clk(clk), .reset(reset), .flush(flush), .commit_store(commit_store),
        .sb_valid(sb_valid), .sb_addr(sb_addr), .sb_strb(sb_strb),
        .sb_lswidth(sb_lswidth), .sb_data(sb_data), .sb_uncached(sb_uncached),
        .sb_pop(sb_pop), .dc_wreq(dc_wreq), .dc_waddr(dc_waddr),
        .dc_wstrb(dc_wstrb), .dc_wdata(dc_wdata), .dc_wready(dc_wready),
        .awvalid(awvalid), .awaddr(awaddr), .awsize(awsize), .awready(awready),
        .wvalid(wvalid), .wdata(wdata), .wstrb(wstrb), .wready(wready),
        .bvalid(bvalid), .bresp(bresp), .bready(bready),
`ifdef STOREDRAIN_BUS_ERROR_EN
        .bus_error(bus_error),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic apply_head();
        if (q.size() > 0) begin
            sb_valid = 1'b1; sb_addr = q[0].addr; sb_strb = q[0].strb;
            sb_lswidth = q[0].lsw; sb_data = q[0].data; sb_uncached = q[0].unc;
        end else begin
            sb_valid = 1'b0; sb_addr = '0; sb_strb = '0;
            sb_lswidth = '0; sb_data = '0; sb_uncached = 1'b0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        commit_store = 1'b0;
        flush = 1'b0;
        apply_head();
    endtask

    task automatic push(input logic [31:0] a, input logic [3:0] s, input logic [1:0] l,
                        input logic [31:0] d, input logic u);
        st_t e;
        e.addr = a; e.strb = s; e.lsw = l; e.data = d; e.unc = u;
        q.push_back(e);
        commit_store = 1'b1;
        apply_head();
    endtask

    task automatic wait_pops(input int target, input int bound);
        int n = 0;
        while (pop_cnt < target && n < bound) begin step(); n++; end
        check("pop_timeout", 32'(pop_cnt >= target), 32'd1);
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while (busy && n < bound) begin step(); n++; end
        check("idle_timeout", 32'(busy), 32'd0);
    endtask

    // D-cache responder: accepts after dc_stall cycles of dc_wreq.
    always @(posedge clk) begin
        #1;
        if (dc_wreq) begin
            dc_wready = (dc_wait >= dc_stall);
            dc_wait++;
        end else begin
            dc_wait = 0;
            dc_wready = (dc_stall == 0);
        end
    end

    // Reference model: head entry defines the request fields; pending counts commits minus pops.
    always @(negedge clk) begin
        if (armed) begin
            check("pending", 32'(dut.r_pending), 32'(m_pending));
            if (prev_pop) check("pop_back_to_back", 32'(sb_pop), 32'd0);
            if (dc_wreq && q.size() > 0) begin
                check("dc_waddr", dc_waddr, q[0].addr & 32'hFFFF_FFFC);
                check("dc_wstrb", 32'(dc_wstrb), 32'(q[0].strb));
                check("dc_wdata", dc_wdata, q[0].data);
                check("dc_cached", 32'(q[0].unc), 32'd0);
            end
            if (awvalid && q.size() > 0) begin
                check("awaddr", awaddr, (q[0].lsw == 2'd2) ? (q[0].addr & 32'hFFFF_FFFC) : q[0].addr);
                check("awsize", 32'(awsize), 32'(q[0].lsw));
                check("aw_uncached", 32'(q[0].unc), 32'd1);
            end
            if (wvalid && q.size() > 0) begin
                check("wdata", wdata, q[0].data);
                check("wstrb", 32'(wstrb), 32'(q[0].strb));
            end
            if (dc_wreq && dc_wready) wlog.push_back(dc_waddr);
            if (awvalid && awready) wlog.push_back(awaddr);
            if (sb_pop) pop_cnt++;
            prev_pop = sb_pop;
            if (reset || flush) begin
                m_pending = 0;
                q.delete();
            end else begin
                if (commit_store && !sb_pop) m_pending = (m_pending < 6) ? m_pending + 1 : 6;
                else if (!commit_store && sb_pop && m_pending > 0) m_pending--;
                if (sb_pop && q.size() > 0) void'(q.pop_front());
            end
        end
    end

    initial begin
        int base;
        reset = 1'b1; flush = 1'b0; commit_store = 1'b0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        dc_wready = 1'b1;
        apply_head();
        step();
        armed = 1'b1;
        step();
        check("rst_sb_pop", 32'(sb_pop), 0);
        check("rst_dc_wreq", 32'(dc_wreq), 0);
        check("rst_awvalid", 32'(awvalid), 0);
        check("rst_wvalid", 32'(wvalid), 0);
        check("rst_bready", 32'(bready), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_dc_waddr", dc_waddr, 0);
        check("rst_awaddr", awaddr, 0);
        reset = 1'b0;
        step();

        // Cached store, immediate accept.
        base = pop_cnt;
        push(32'h1000_0004, 4'b0011, 2'd1, 32'hAABB_CCDD, 1'b0);
        step();
        check("t1_dc_wreq", 32'(dc_wreq), 1);
        check("t1_dc_waddr", dc_waddr, 32'h1000_0004);
        check("t1_pop_early", 32'(sb_pop), 0);
        step();
        check("t1_dc_wreq_drop", 32'(dc_wreq), 0);
        check("t1_pop", 32'(sb_pop), 1);
        step();
        check("t1_pop_single", 32'(sb_pop), 0);
        check("t1_pending", 32'(dut.r_pending), 0);
        check("t1_pops", 32'(pop_cnt - base), 1);

        // Uncached word: awready at +1, wready at +3, bvalid at +5.
        base = pop_cnt;
        push(32'h1FC0_0000, 4'hF, 2'd2, 32'h1234_5678, 1'b1);
        step();
        awready = 1'b1;
        check("t2_awvalid", 32'(awvalid), 1);
        check("t2_wvalid", 32'(wvalid), 1);
        check("t2_awsize", 32'(awsize), 32'd2);
        check("t2_awaddr", awaddr, 32'h1FC0_0000);
        step();
        awready = 1'b0;
        check("t2_aw_done", 32'(awvalid), 0);
        check("t2_w_held", 32'(wvalid), 1);
        check("t2_bready_early", 32'(bready), 0);
        step();
        wready = 1'b1;
        check("t2_bready_early2", 32'(bready), 0);
        step();
        wready = 1'b0;
        check("t2_w_done", 32'(wvalid), 0);
        check("t2_bready", 32'(bready), 1);
        step();
        bvalid = 1'b1;
        check("t2_no_pop", 32'(sb_pop), 0);
        step();
        bvalid = 1'b0;
        check("t2_pop", 32'(sb_pop), 1);
        check("t2_bready_drop", 32'(bready), 0);
        step();
        check("t2_busy", 32'(busy), 0);
        check("t2_pops", 32'(pop_cnt - base), 1);

        // Three back-to-back commits, each write stalled 4 cycles.
        dc_stall = 4;
        wlog.delete();
        base = pop_cnt;
        push(32'h2000_0000, 4'hF, 2'd2, 32'h0000_0001, 1'b0);
        step();
        push(32'h2000_0104, 4'hF, 2'd2, 32'h0000_0002, 1'b0);
        check("t3_pend1", 32'(dut.r_pending), 1);
        step();
        push(32'h2000_020B, 4'hF, 2'd2, 32'h0000_0003, 1'b0);
        check("t3_pend2", 32'(dut.r_pending), 2);
        step();
        check("t3_pend3", 32'(dut.r_pending), 3);
        wait_pops(base + 3, 200);
        wait_idle(20);
        check("t3_pops", 32'(pop_cnt - base), 3);
        check("t3_nwrites", 32'(wlog.size()), 3);
        if (wlog.size() == 3) begin
            check("t3_order0", wlog[0], 32'h2000_0000);
            check("t3_order1", wlog[1], 32'h2000_0104);
            check("t3_order2", wlog[2], 32'h2000_0208);
        end

        // Flush during URESP: B still accepted, no pop.
        base = pop_cnt;
        push(32'h1FC0_0013, 4'b1000, 2'd0, 32'h5500_0000, 1'b1);
        awready = 1'b1; wready = 1'b1;
        step();
        check("t4_awaddr", awaddr, 32'h1FC0_0013);
        check("t4_awsize", 32'(awsize), 32'd0);
        step();
        awready = 1'b0; wready = 1'b0;
        check("t4_bready", 32'(bready), 1);
        flush = 1'b1;
        step();
        step();
        bvalid = 1'b1;
        step();
        bvalid = 1'b0;
        check("t4_no_pop", 32'(sb_pop), 0);
        check("t4_bready_drop", 32'(bready), 0);
        check("t4_pending", 32'(dut.r_pending), 0);
        step();
        check("t4_no_pop2", 32'(sb_pop), 0);
        check("t4_idle", 32'(busy), 0);
        check("t4_pops", 32'(pop_cnt - base), 0);

        // Commit coinciding with a pop while pending=2.
        dc_stall = 2;
        base = pop_cnt;
        push(32'h3000_0000, 4'h1, 2'd0, 32'h0000_00A1, 1'b0);
        step();
        push(32'h3000_0010, 4'h3, 2'd1, 32'h0000_B2B2, 1'b0);
        step();
        begin
            int n = 0;
            while (!sb_pop && n < 50) begin step(); n++; end
        end
        check("t5_pop_seen", 32'(sb_pop), 1);
        check("t5_pend_before", 32'(dut.r_pending), 2);
        push(32'h3000_0020, 4'hF, 2'd2, 32'hC3C3_C3C3, 1'b0);
        step();
        check("t5_pend_after", 32'(dut.r_pending), 2);
        wait_pops(base + 3, 200);
        wait_idle(20);
        check("t5_pops", 32'(pop_cnt - base), 3);
        dc_stall = 0;

        // Commits with no valid head: counter saturates, nothing issued.
        repeat (7) begin
            commit_store = 1'b1;
            step();
        end
        step();
        check("t6_sat", 32'(dut.r_pending), 6);
        check("t6_busy", 32'(busy), 1);
        check("t6_no_dc", 32'(dc_wreq), 0);
        check("t6_no_aw", 32'(awvalid), 0);
        flush = 1'b1;
        step();
        check("t6_flush_pend", 32'(dut.r_pending), 0);
        check("t6_flush_busy", 32'(busy), 0);

        // Reset mid-AXI.
        push(32'h1FC0_0100, 4'hF, 2'd2, 32'h7777_0000, 1'b1);
        step();
        check("t7_awvalid", 32'(awvalid), 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t7_aw_rst", 32'(awvalid), 0);
        check("t7_w_rst", 32'(wvalid), 0);
        check("t7_busy_rst", 32'(busy), 0);
        step();

`ifdef STOREDRAIN_BUS_ERROR_EN
        base = pop_cnt;
        push(32'h1FC0_0040, 4'hF, 2'd2, 32'hDEAD_BEEF, 1'b1);
        awready = 1'b1; wready = 1'b1;
        step();
        check("t8_awvalid", 32'(awvalid), 1);
        step();
        awready = 1'b0; wready = 1'b0;
        check("t8_bready", 32'(bready), 1);
        check("t8_err_clear", 32'(bus_error), 0);
        bvalid = 1'b1; bresp = 2'b10;
        step();
        bvalid = 1'b0; bresp = 2'b00;
        check("t8_bus_error", 32'(bus_error), 1);
        check("t8_pop", 32'(sb_pop), 1);
        step();
        step();
        check("t8_sticky", 32'(bus_error), 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t8_err_reset", 32'(bus_error), 0);
        step();
`endif

        check("final_pending", 32'(dut.r_pending), 32'(m_pending));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/execute_mem_storedrain.md
# execute_mem_storedrain

Drains committed stores from the head of the memory-stage store buffer into memory. It counts ROB store commits and, for each committed head entry, issues either a D-cache write (cached) or an AXI4-Lite single-beat write (uncached). On completion it pops the store buffer. It sits between the store buffer's head/commit port and the D-cache write port / uncached bus bridge.

## Interface
Parameters:
- PEND_W, default 3: width of the committed-store counter (store buffer depth 6).

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  snoop_hit | bco_valid; store buffer cleared the same edge.
- commit_store  in  1  ROB committed one store this cycle.
- sb_valid  in  1  head entry valid.
- sb_addr  in  32  head address.
- sb_strb  in  4  head byte strobes.
- sb_lswidth  in  2  0=byte, 1=half, 2=word.
- sb_data  in  32  head data.
- sb_uncached  in  1  head is uncached.
- sb_pop  out  1  single-cycle pop of head; drives store buffer wec.
- dc_wreq, dc_waddr[31:0], dc_wstrb[3:0], dc_wdata[31:0]  out  D-cache write request.
- dc_wready  in  1  D-cache accepts request.
- awvalid out 1, awaddr out 32, awsize out 3, awready in 1  AXI write address.
- wvalid out 1, wdata out 32, wstrb out 4, wready in 1  AXI write data.
- bvalid in 1, bresp in 2, bready out 1  AXI write response.
- busy  out  1  state != IDLE or pending != 0.

## Operation
- pending counter: +1 on commit_store, -1 on sb_pop, unchanged when both occur. Saturates at 6. Cleared by flush.
- States: IDLE, CWR, UADDR, URESP.
- IDLE: if pending != 0 and sb_valid, latch head into request registers.
  - sb_uncached=0 goes to CWR.
  - Otherwise go to UADDR with awvalid=wvalid=1.
- CWR: hold dc_wreq until dc_wreq & dc_wready. Then pulse sb_pop and go to IDLE.
- UADDR: awvalid and wvalid drop independently on their own handshakes. When both have been accepted (same or different cycles), go to URESP with bready=1.
- URESP: on bvalid go to IDLE and pulse sb_pop.
- awaddr = {sb_addr[31:2], 2'b00} if lswidth=2, else sb_addr. awsize = {1'b0, lswidth}.
- dc_waddr = {sb_addr[31:2], 2'b00}.
- flush while in CWR with no handshake that cycle: drop dc_wreq next cycle and go to IDLE, no pop.
- flush while in UADDR/URESP: the AXI transaction completes (no abort), but sb_pop is suppressed for that transaction.
- flush in IDLE: counter cleared only.
- reset: IDLE and pending=0 immediately, even mid-AXI. Bus-side consequences of that are the system's responsibility.
- sb_valid=0 while pending != 0: stay IDLE (no fault).

## Timing
- Reset values: sb_pop=0, dc_wreq=0, awvalid=0, wvalid=0, bready=0, busy=0. Address/data registers are 0.
- All outputs are registered except busy.
- Cached store: commit at cycle N, dc_wreq at N+1. With dc_wready=1 at N+1, sb_pop=1 at N+2 and the next request starts at N+3 earliest.
- Uncached store: awvalid/wvalid at N+1, bready the cycle after both are accepted, sb_pop the cycle after the bvalid handshake.
- Only one outstanding transaction at a time.
- sb_pop is never asserted on consecutive cycles.

## Configuration
- STOREDRAIN_BUS_ERROR_EN defined:
  - Adds output bus_error (1 bit), sticky-set on a B handshake with bresp != 2'b00.
  - Cleared only by reset.
  - The store is still popped.
- STOREDRAIN_BUS_ERROR_EN undefined: port absent and bresp ignored.

## Structure
- Shared package holds:
  - state enum (IDLE/CWR/UADDR/URESP)
  - lswidth encodings
  - AXI BRESP constants (OKAY=2'b00)
  - store buffer depth constant (6).
- One sub-module, execute_mem_storedrain_axiw, owns the AW/W independent-handshake tracking and B acceptance.
  - Start: pulse start plus latched fields.
  - Done: done pulse plus bresp.

## Test plan
- Cached store 0x1000_0004, strb 4'b0011, data 0xAABB_CCDD, commit, dc_wready tied 1 -> dc_wreq one cycle with dc_waddr 0x1000_0004; sb_pop one cycle later; pending returns to 0.
- Uncached word 0x1FC0_0000; awready at +1, wready at +3, bvalid at +5 -> awsize=2; bready only after both accepts; exactly one sb_pop after B.
- Three commits back-to-back, dc_wready stalled 4 cycles on each -> three in-order writes, three sb_pops, pending sequence 1,2,3 then decrements to 0.
- flush during URESP with bvalid two cycles later -> B accepted, no sb_pop, pending=0, state IDLE.
- commit_store and sb_pop in the same cycle with pending=2 -> pending stays 2.
- With STOREDRAIN_BUS_ERROR_EN, bresp=2'b10 -> bus_error=1, store popped, bus_error stays 1 until reset.
